// File: rtl/mem_arbiter.sv
// Shares one memory port between an instruction fetch requester and a data
// requester. Data wins collisions until fetch has waited STARVE_LIMIT grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        mdr_load,
    output logic        mdr_instr_data
);
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_serve_rd;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wmask;
    logic             r_op_write;

    always_comb begin
        w_next_state   = r_state;
        w_grant_i      = 1'b0;
        w_grant_d      = 1'b0;
        w_serve_rd     = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_wmask      = r_wmask;
        i_resp         = 1'b0;
        d_resp         = 1'b0;
        mdr_load       = 1'b0;
        mdr_instr_data = 1'b0;

        case (r_state)
            IDLE: begin
                // Data has priority unless fetch has been passed over too often.
                if ((d_read || d_write) && !(i_read && (r_starve_cnt == CNT_MAX))) begin
                    w_grant_d    = 1'b1;
                    w_next_state = SERVE_D;
                end else if (i_read) begin
                    w_grant_i    = 1'b1;
                    w_next_state = SERVE_I;
                end
            end
            SERVE_I: begin
                mem_wmask  = 4'h0;
                w_serve_rd = 1'b1;
                i_resp     = mem_resp && rst_n;
                if (mem_resp) w_next_state = IDLE;
            end
            SERVE_D: begin
                w_serve_rd     = !r_op_write;
                mem_write      = r_op_write && rst_n;
                d_resp         = mem_resp && rst_n;
                mdr_instr_data = rst_n;
                if (mem_resp) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase

        mem_read = w_serve_rd && rst_n;
        mdr_load = w_serve_rd && mem_resp && rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_op_write   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_addr       <= i_addr;
                r_starve_cnt <= '0;
            end
            if (w_grant_d) begin
                r_addr     <= d_addr;
                r_wdata    <= d_wdata;
                r_wmask    <= d_wmask;
                r_op_write <= d_write;
                if (i_read && (r_starve_cnt != CNT_MAX))
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
